// File: rtl/regfile_wr_arbiter_if.sv
// Request/write bundle between requesters, the write arbiter and the SRAM write ports.
interface regfile_wr_arbiter_if #(
  parameter int REQS    = 4,
  parameter int W_PORTS = 2,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [REQS-1:0]                req_valid;
  logic [REQS-1:0][AW-1:0]        req_addr;
  logic [REQS-1:0][WIDTH-1:0]     req_data;
  logic [REQS-1:0]                req_ready;
  logic [W_PORTS-1:0]             w_e;
  logic [W_PORTS-1:0][AW-1:0]     w_addr;
  logic [W_PORTS-1:0][WIDTH-1:0]  w_data;
  logic                           init_done;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, w_e, w_addr, w_data, init_done
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, w_e, w_addr, w_data, init_done
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Clears SRAM entries 1..DEPTH-1 after reset, then round-robin arbitrates
// requester writes onto W_PORTS registered SRAM write ports.
module regfile_wr_arbiter #(
  parameter int REQS    = 4,
  parameter int W_PORTS = 2,
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wr_arbiter_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = (REQS > 1) ? $clog2(REQS) : 1;
  localparam int CW = $clog2(DEPTH + W_PORTS) + 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t                          state;
  logic [CW-1:0]                   cnt;
  logic [PW-1:0]                   rr_ptr;
  logic [PW-1:0]                   rr_next;
  logic [PW-1:0]                   idx;
  logic                            clash;
  int unsigned                     used;
  logic [REQS-1:0]                 ready;
  logic [W_PORTS-1:0]              nxt_e;
  logic [W_PORTS-1:0][AW-1:0]      nxt_addr;
  logic [W_PORTS-1:0][WIDTH-1:0]   nxt_data;

  // Scan from rr_ptr; address-0 requests are acked without taking a port,
  // and an address already granted this cycle stalls later requesters.
  always_comb begin
    ready    = '0;
    nxt_e    = '0;
    nxt_addr = '0;
    nxt_data = '0;
    rr_next  = rr_ptr;
    idx      = '0;
    clash    = 1'b0;
    used     = 0;
    if (state == RUN) begin
      for (int unsigned i = 0; i < REQS; i++) begin
        idx = PW'((32'(rr_ptr) + i) % REQS);
        if (bus.req_valid[idx]) begin
          if (bus.req_addr[idx] == '0) begin
            ready[idx] = 1'b1;
            rr_next    = PW'((32'(idx) + 1) % REQS);
          end else begin
            clash = 1'b0;
            for (int unsigned p = 0; p < W_PORTS; p++) begin
              if (nxt_e[p] && nxt_addr[p] == bus.req_addr[idx]) clash = 1'b1;
            end
            if (!clash && used < W_PORTS) begin
              ready[idx] = 1'b1;
              for (int unsigned p = 0; p < W_PORTS; p++) begin
                if (p == used) begin
                  nxt_e[p]    = 1'b1;
                  nxt_addr[p] = bus.req_addr[idx];
                  nxt_data[p] = bus.req_data[idx];
                end
              end
              used    = used + 1;
              rr_next = PW'((32'(idx) + 1) % REQS);
            end
          end
        end
      end
    end
  end

  assign bus.req_ready = ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT;
      cnt           <= CW'(1);
      rr_ptr        <= '0;
      bus.w_e       <= '0;
      bus.w_addr    <= '0;
      bus.w_data    <= '0;
      bus.init_done <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          for (int unsigned k = 0; k < W_PORTS; k++) begin
            if (32'(cnt) + k < 32'(DEPTH)) begin
              bus.w_e[k]    <= 1'b1;
              bus.w_addr[k] <= AW'(32'(cnt) + k);
            end else begin
              bus.w_e[k]    <= 1'b0;
              bus.w_addr[k] <= '0;
            end
            bus.w_data[k] <= '0;
          end
          // Counter past the last entry means the final clear beat is already on the ports.
          if (32'(cnt) >= 32'(DEPTH)) begin
            state         <= RUN;
            bus.init_done <= 1'b1;
          end else begin
            cnt <= cnt + CW'(W_PORTS);
          end
        end
        RUN: begin
          bus.w_e    <= nxt_e;
          bus.w_addr <= nxt_addr;
          bus.w_data <= nxt_data;
          rr_ptr     <= rr_next;
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed and random checks of the regfile write arbiter against hand-derived values.
module tb_regfile_wr_arbiter;
  localparam int REQS  = 4;
  localparam int WP    = 2;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   zero_hits = 0;

  logic [WIDTH-1:0] sram [DEPTH];
  logic [WIDTH-1:0] model [DEPTH];

  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.REQS(REQS), .W_PORTS(WP), .WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  regfile_wr_arbiter #(.REQS(REQS), .W_PORTS(WP), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // SRAM emulation driven by the DUT write ports.
  always @(posedge clk) begin
    for (int p = 0; p < WP; p++) begin
      if (bus.w_e[p] === 1'b1) begin
        sram[bus.w_addr[p]] <= bus.w_data[p];
        if (bus.w_addr[p] == '0) zero_hits <= zero_hits + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input logic [3:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    bus.req_valid   = v;
    bus.req_addr[0] = a0;
    bus.req_addr[1] = a1;
    bus.req_addr[2] = a2;
    bus.req_addr[3] = a3;
  endtask

  task automatic test_reset();
    logic [1:0]    exp_e  [4] = '{2'b11, 2'b11, 2'b11, 2'b01};
    logic [AW-1:0] exp_a0 [4] = '{3'd1, 3'd3, 3'd5, 3'd7};
    logic [AW-1:0] exp_a1 [4] = '{3'd2, 3'd4, 3'd6, 3'd0};
    rst = 1'b1;
    set_req(4'b1111, 3'd3, 3'd3, 3'd3, 3'd3);
    for (int r = 0; r < REQS; r++) bus.req_data[r] = 32'hFFFF_0000 + r;
    tick();
    tick();
    vectors++;
    if (bus.w_e !== 2'b00) begin miscompares++; $display("FAIL reset_w_e got %b want 00", bus.w_e); end
    vectors++;
    if (bus.init_done !== 1'b0) begin miscompares++; $display("FAIL reset_init_done got %b want 0", bus.init_done); end
    vectors++;
    if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_ready got %b want 0000", bus.req_ready); end
    rst = 1'b0;
    for (int b = 0; b < 4; b++) begin
      tick();
      vectors++;
      if (bus.w_e !== exp_e[b]) begin miscompares++; $display("FAIL init_beat%0d_w_e got %b want %b", b, bus.w_e, exp_e[b]); end
      vectors++;
      if (bus.w_addr[0] !== exp_a0[b] || bus.w_data[0] !== '0) begin
        miscompares++; $display("FAIL init_beat%0d_port0 got a=%0d d=%h want a=%0d d=0", b, bus.w_addr[0], bus.w_data[0], exp_a0[b]);
      end
      if (exp_e[b][1]) begin
        vectors++;
        if (bus.w_addr[1] !== exp_a1[b] || bus.w_data[1] !== '0) begin
          miscompares++; $display("FAIL init_beat%0d_port1 got a=%0d d=%h want a=%0d d=0", b, bus.w_addr[1], bus.w_data[1], exp_a1[b]);
        end
      end
      vectors++;
      if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL init_beat%0d_ready got %b want 0000", b, bus.req_ready); end
      vectors++;
      if (bus.init_done !== 1'b0) begin miscompares++; $display("FAIL init_beat%0d_done got %b want 0", b, bus.init_done); end
    end
    bus.req_valid = '0;
    tick();
    vectors++;
    if (bus.init_done !== 1'b1) begin miscompares++; $display("FAIL init_done_rise got %b want 1", bus.init_done); end
    vectors++;
    if (bus.w_e !== 2'b00) begin miscompares++; $display("FAIL init_done_w_e got %b want 00", bus.w_e); end
  endtask

  task automatic test_rr_scan();
    set_req(4'b1111, 3'd3, 3'd5, 3'd6, 3'd7);
    for (int r = 0; r < REQS; r++) bus.req_data[r] = 32'h1000_0000 + r;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0011) begin miscompares++; $display("FAIL rr_first_ready got %b want 0011", bus.req_ready); end
    tick();
    vectors++;
    if (bus.w_e !== 2'b11 || bus.w_addr[0] !== 3'd3 || bus.w_addr[1] !== 3'd5 ||
        bus.w_data[0] !== 32'h1000_0000 || bus.w_data[1] !== 32'h1000_0001) begin
      miscompares++; $display("FAIL rr_first_write got e=%b a=%0d,%0d d=%h,%h want e=11 a=3,5 d=10000000,10000001",
                              bus.w_e, bus.w_addr[0], bus.w_addr[1], bus.w_data[0], bus.w_data[1]);
    end
    bus.req_valid = 4'b1100;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b1100) begin miscompares++; $display("FAIL rr_second_ready got %b want 1100", bus.req_ready); end
    tick();
    vectors++;
    if (bus.w_e !== 2'b11 || bus.w_addr[0] !== 3'd6 || bus.w_addr[1] !== 3'd7 ||
        bus.w_data[0] !== 32'h1000_0002 || bus.w_data[1] !== 32'h1000_0003) begin
      miscompares++; $display("FAIL rr_second_write got e=%b a=%0d,%0d d=%h,%h want e=11 a=6,7 d=10000002,10000003",
                              bus.w_e, bus.w_addr[0], bus.w_addr[1], bus.w_data[0], bus.w_data[1]);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_same_addr();
    set_req(4'b0011, 3'd4, 3'd4, 3'd0, 3'd0);
    bus.req_data[0] = 32'hAAAA_AAAA;
    bus.req_data[1] = 32'hBBBB_BBBB;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL same_addr_ready1 got %b want 0001", bus.req_ready); end
    tick();
    vectors++;
    if (bus.w_e !== 2'b01 || bus.w_addr[0] !== 3'd4 || bus.w_data[0] !== 32'hAAAA_AAAA) begin
      miscompares++; $display("FAIL same_addr_write1 got e=%b a=%0d d=%h want e=01 a=4 d=aaaaaaaa", bus.w_e, bus.w_addr[0], bus.w_data[0]);
    end
    bus.req_valid = 4'b0010;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0010) begin miscompares++; $display("FAIL same_addr_ready2 got %b want 0010", bus.req_ready); end
    tick();
    vectors++;
    if (bus.w_e !== 2'b01 || bus.w_addr[0] !== 3'd4 || bus.w_data[0] !== 32'hBBBB_BBBB) begin
      miscompares++; $display("FAIL same_addr_write2 got e=%b a=%0d d=%h want e=01 a=4 d=bbbbbbbb", bus.w_e, bus.w_addr[0], bus.w_data[0]);
    end
    bus.req_valid = '0;
    tick();
    vectors++;
    if (sram[4] !== 32'hBBBB_BBBB) begin miscompares++; $display("FAIL same_addr_final got %h want bbbbbbbb", sram[4]); end
  endtask

  task automatic test_addr0();
    // Pointer is 2 here; an addr-0 ack from requester 3 brings it back to 0.
    set_req(4'b1000, 3'd0, 3'd0, 3'd0, 3'd0);
    #1;
    vectors++;
    if (bus.req_ready !== 4'b1000) begin miscompares++; $display("FAIL addr0_solo_ready got %b want 1000", bus.req_ready); end
    tick();
    vectors++;
    if (bus.w_e !== 2'b00) begin miscompares++; $display("FAIL addr0_solo_w_e got %b want 00", bus.w_e); end
    set_req(4'b1111, 3'd2, 3'd3, 3'd0, 3'd1);
    for (int r = 0; r < REQS; r++) bus.req_data[r] = 32'h2000_0000 + r;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0111) begin miscompares++; $display("FAIL addr0_mix_ready got %b want 0111", bus.req_ready); end
    tick();
    vectors++;
    if (bus.w_e !== 2'b11 || bus.w_addr[0] !== 3'd2 || bus.w_addr[1] !== 3'd3 ||
        bus.w_data[0] !== 32'h2000_0000 || bus.w_data[1] !== 32'h2000_0001) begin
      miscompares++; $display("FAIL addr0_mix_write got e=%b a=%0d,%0d d=%h,%h want e=11 a=2,3 d=20000000,20000001",
                              bus.w_e, bus.w_addr[0], bus.w_addr[1], bus.w_data[0], bus.w_data[1]);
    end
    bus.req_valid = 4'b1000;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b1000) begin miscompares++; $display("FAIL addr0_req3_ready got %b want 1000", bus.req_ready); end
    tick();
    vectors++;
    if (bus.w_e !== 2'b01 || bus.w_addr[0] !== 3'd1 || bus.w_data[0] !== 32'h2000_0003) begin
      miscompares++; $display("FAIL addr0_req3_write got e=%b a=%0d d=%h want e=01 a=1 d=20000003", bus.w_e, bus.w_addr[0], bus.w_data[0]);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_reset_mid_run();
    set_req(4'b0001, 3'd5, 3'd0, 3'd0, 3'd0);
    bus.req_data[0] = 32'h3333_3333;
    #1;
    vectors++;
    if (bus.req_ready !== 4'b0001) begin miscompares++; $display("FAIL midrun_ready got %b want 0001", bus.req_ready); end
    rst = 1'b1;
    tick();
    vectors++;
    if (bus.w_e !== 2'b00 || bus.init_done !== 1'b0) begin
      miscompares++; $display("FAIL midrun_drop got e=%b done=%b want e=00 done=0", bus.w_e, bus.init_done);
    end
    vectors++;
    if (bus.req_ready !== 4'b0000) begin miscompares++; $display("FAIL midrun_ready_rst got %b want 0000", bus.req_ready); end
    bus.req_valid = '0;
  endtask

  task automatic test_reset_mid_init();
    rst = 1'b0;
    tick();
    vectors++;
    if (bus.w_e !== 2'b11 || bus.w_addr[0] !== 3'd1 || bus.w_addr[1] !== 3'd2) begin
      miscompares++; $display("FAIL midinit_beat1 got e=%b a=%0d,%0d want e=11 a=1,2", bus.w_e, bus.w_addr[0], bus.w_addr[1]);
    end
    tick();
    vectors++;
    if (bus.w_e !== 2'b11 || bus.w_addr[0] !== 3'd3 || bus.w_addr[1] !== 3'd4) begin
      miscompares++; $display("FAIL midinit_beat2 got e=%b a=%0d,%0d want e=11 a=3,4", bus.w_e, bus.w_addr[0], bus.w_addr[1]);
    end
    rst = 1'b1;
    tick();
    vectors++;
    if (bus.w_e !== 2'b00 || bus.init_done !== 1'b0) begin
      miscompares++; $display("FAIL midinit_rst got e=%b done=%b want e=00 done=0", bus.w_e, bus.init_done);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (bus.w_e !== 2'b11 || bus.w_addr[0] !== 3'd1 || bus.w_addr[1] !== 3'd2) begin
      miscompares++; $display("FAIL midinit_restart got e=%b a=%0d,%0d want e=11 a=1,2", bus.w_e, bus.w_addr[0], bus.w_addr[1]);
    end
    tick();
    tick();
    tick();
    vectors++;
    if (bus.w_e !== 2'b01 || bus.w_addr[0] !== 3'd7 || bus.init_done !== 1'b0) begin
      miscompares++; $display("FAIL midinit_last got e=%b a=%0d done=%b want e=01 a=7 done=0", bus.w_e, bus.w_addr[0], bus.init_done);
    end
    tick();
    vectors++;
    if (bus.init_done !== 1'b1 || bus.w_e !== 2'b00) begin
      miscompares++; $display("FAIL midinit_done got done=%b e=%b want done=1 e=00", bus.init_done, bus.w_e);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0]    pa [REQS];
    logic [WIDTH-1:0] pd [REQS];
    bit               pv [REQS];
    int               waits [REQS];
    logic [AW-1:0]    ea [WP];
    logic [WIDTH-1:0] ed [WP];
    bit               taken [WP];
    int               ne = 0;
    int               n_en;
    bit               found;
    bit               pending;
    int               cyc = 0;
    for (int a = 0; a < DEPTH; a++) model[a] = '0;
    for (int r = 0; r < REQS; r++) begin pv[r] = 1'b0; waits[r] = 0; pa[r] = '0; pd[r] = '0; end
    forever begin
      if (cyc > 0) begin
        n_en = 0;
        for (int q = 0; q < WP; q++) taken[q] = 1'b0;
        for (int p = 0; p < WP; p++) begin
          if (bus.w_e[p] === 1'b1) begin
            n_en++;
            vectors++;
            if (bus.w_addr[p] == '0) begin miscompares++; $display("FAIL rand_addr0_enabled cyc=%0d port=%0d got a=0 want nonzero", cyc, p); end
            found = 1'b0;
            for (int q = 0; q < ne; q++) begin
              if (!found && !taken[q] && ea[q] == bus.w_addr[p] && ed[q] == bus.w_data[p]) begin
                taken[q] = 1'b1;
                found = 1'b1;
              end
            end
            vectors++;
            if (!found) begin miscompares++; $display("FAIL rand_port_write cyc=%0d port=%0d got a=%0d d=%h want an accepted write", cyc, p, bus.w_addr[p], bus.w_data[p]); end
          end
        end
        vectors++;
        if (n_en != ne) begin miscompares++; $display("FAIL rand_port_count cyc=%0d got %0d want %0d", cyc, n_en, ne); end
      end
      pending = 1'b0;
      for (int r = 0; r < REQS; r++) pending = pending | pv[r];
      if (cyc >= 300 && !pending) break;
      if (cyc >= 400) begin
        miscompares++; $display("FAIL rand_drain got pending requests want none by cycle 400");
        break;
      end
      for (int r = 0; r < REQS; r++) begin
        if (!pv[r] && cyc < 300 && $urandom_range(0, 2) != 0) begin
          pv[r] = 1'b1;
          pa[r] = AW'($urandom_range(0, DEPTH - 1));
          pd[r] = $urandom;
          waits[r] = 0;
        end
        bus.req_valid[r] = pv[r];
        bus.req_addr[r]  = pa[r];
        bus.req_data[r]  = pd[r];
      end
      #1;
      ne = 0;
      for (int r = 0; r < REQS; r++) begin
        if (pv[r] && bus.req_ready[r] === 1'b1) begin
          if (pa[r] != '0) begin
            for (int q = 0; q < ne; q++) begin
              vectors++;
              if (ea[q] == pa[r]) begin miscompares++; $display("FAIL rand_dup_addr cyc=%0d got two grants to a=%0d want one", cyc, pa[r]); end
            end
            vectors++;
            if (ne >= WP) begin
              miscompares++; $display("FAIL rand_overgrant cyc=%0d got %0d grants want at most %0d", cyc, ne + 1, WP);
            end else begin
              ea[ne] = pa[r];
              ed[ne] = pd[r];
              ne++;
            end
            model[pa[r]] = pd[r];
          end
          pv[r] = 1'b0;
        end else if (pv[r]) begin
          waits[r]++;
          if (waits[r] > 16) begin
            miscompares++; $display("FAIL rand_starve req=%0d got wait>16 want grant", r);
            waits[r] = 0;
          end
        end
      end
      tick();
      cyc++;
    end
    bus.req_valid = '0;
    tick();
    for (int a = 1; a < DEPTH; a++) begin
      vectors++;
      if (sram[a] !== model[a]) begin miscompares++; $display("FAIL rand_mem[%0d] got %h want %h", a, sram[a], model[a]); end
    end
    vectors++;
    if (zero_hits != 0) begin miscompares++; $display("FAIL addr0_never_written got %0d writes want 0", zero_hits); end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    test_reset();
    test_rr_scan();
    test_same_addr();
    test_addr0();
    test_reset_mid_run();
    test_reset_mid_init();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter REQS, default 4, number of write requesters.
REQ-002 Parameter W_PORTS, default 2, number of duplex-SRAM write ports driven.
REQ-003 Parameter WIDTH, default 32, data width.
REQ-004 Parameter DEPTH, default 8, SRAM entries; AW = $clog2(DEPTH).
REQ-005 i_clk  in  1  single clock, all state on rising edge.
REQ-006 i_rst  in  1  synchronous, active-high reset.
REQ-007 i_req_valid  in  [REQS-1:0]  requester has a write pending.
REQ-008 i_req_addr  in  [AW-1:0] x REQS  write address per requester.
REQ-009 i_req_data  in  [WIDTH-1:0] x REQS  write data per requester.
REQ-010 o_req_ready  out  [REQS-1:0]  request accepted this cycle (valid & ready = handshake).
REQ-011 o_w_e  out  [W_PORTS-1:0]  write enable to SRAM write ports.
REQ-012 o_w_addr  out  [AW-1:0] x W_PORTS  SRAM write address.
REQ-013 o_w_data  out  [WIDTH-1:0] x W_PORTS  SRAM write data.
REQ-014 o_init_done  out  1  high once the clear sequence has finished.

Function
REQ-015 FSM states INIT and RUN; reset enters INIT; INIT -> RUN after the last clear write is issued; RUN persists until reset.
REQ-016 INIT: clear counter starts at 1; each cycle drives o_w_e[k]=1, o_w_addr[k]=cnt+k, o_w_data[k]=0 for every k with cnt+k <= DEPTH-1, others o_w_e[k]=0; cnt += W_PORTS.
REQ-017 INIT: o_req_ready all zero; address 0 never written.
REQ-018 o_init_done rises the cycle after the final clear beat is driven, stays high until reset.
REQ-019 RUN: ready is combinational from valid, address and round-robin pointer rr_ptr; outputs o_w_* are registered (handshake in cycle N -> o_w_* presented in cycle N+1 -> SRAM commits at end of N+1).
REQ-020 Scan order: requesters rr_ptr, rr_ptr+1, ... modulo REQS; each valid requester considered once per cycle.
REQ-021 Valid request with addr 0: ready=1, consumes no port, produces no write.
REQ-022 Valid request with nonzero addr: ready=1 iff a free port remains and no earlier-scanned requester granted the same address this cycle; otherwise ready=0 (stall, retry next cycle).
REQ-023 The i-th granted nonzero-address request (scan order) occupies port i; unused ports o_w_e=0; o_w_addr/o_w_data of disabled ports are don't-care.
REQ-024 Consequence: at most one write per address per cycle; same-address writes commit in scan order over successive cycles.
REQ-025 rr_ptr resets to 0; after any cycle with at least one handshake (including addr-0), rr_ptr = (last handshaken requester in scan order + 1) mod REQS; unchanged otherwise.
REQ-026 Requesters shall hold valid/addr/data stable until handshake; block does not check this.
REQ-027 Throughput: up to W_PORTS nonzero-address writes per cycle, unlimited addr-0 acks.

Reset
REQ-028 On i_rst high at any edge (including mid-INIT or mid-RUN): state=INIT, cnt=1, rr_ptr=0, o_w_e=0, o_init_done=0, o_req_ready=0 during and after; any in-flight registered write is dropped.
REQ-029 Clear sequence restarts from address 1 after every reset deassertion; DEPTH=8, W_PORTS=2 takes 4 beats: (1,2),(3,4),(5,6),(7).

Verification
REQ-030 Reset release, defaults: beats write {1,2},{3,4},{5,6},{7 only, o_w_e=2'b01} data 0; o_init_done=1 on 5th cycle; ready=0 throughout INIT.
REQ-031 RUN, rr_ptr=0, all 4 valid, addrs 3,5,6,7 -> ready=4'b0011, next cycle ports write 3,5; rr_ptr=2; following cycle ready=4'b1100, writes 6,7.
REQ-032 Req0 and req1 both addr 4 (data A, B), others idle -> cycle1 only req0 ready, writes A; cycle2 req1 ready, writes B; final entry 4 = B.
REQ-033 Req2 addr 0 plus req0 addr 2, req1 addr 3, req3 addr 1 with rr_ptr=0 -> ready=4'b0111 (addr-0 ack without port), writes 2,3; req3 granted next cycle.
REQ-034 Assert i_rst during 2nd INIT beat -> next cycle o_w_e=0, o_init_done=0; after release clear restarts at address 1.
REQ-035 Random traffic vs. reference model of SRAM contents: every accepted nonzero write lands exactly once, same-address order preserved, no port double-used, address 0 never enabled.
